// File: rtl/ex_issue.sv
// ex_issue: execute-stage issue register sitting directly in front of the ALU.
//
// Each handshake accepts one raw RV32I instruction with its PC and register
// file operands. The block decodes the ALU-class opcodes (OP, OP-IMM, LUI,
// AUIPC) and resolves bypassing from EX/MEM and MEM/WB. It then registers the
// ALU operands, the 4-bit ALU select and the destination info into a one-entry
// valid/ready pipeline register that supports flush.
//
// Ports
//   clk_i, rst_ni              clock, synchronous active-low reset
//   in_valid_i / in_ready_o    upstream handshake (in_ready_o is combinational)
//   in_instr_i, in_pc_i        instruction word and its PC
//   in_rs1_val_i, in_rs2_val_i register file read data
//   fwd_exm_*_i                EX/MEM bypass (valid, rd, data)
//   fwd_wb_*_i                 MEM/WB bypass (valid, rd, data)
//   flush_i                    drop held entry and refuse same-cycle input
//   out_valid_o / out_ready_i  downstream handshake
//   out_arg_a_o, out_arg_b_o   ALU operands
//   out_alu_sel_o              1 ADD 2 SUB 3 XOR 4 OR 5 AND 6 SLL 7 SRL 8 SRA
//                              9 SLT A SLTU, 0 none
//   out_rd_o, out_rd_we_o      destination register and write enable
//   out_illegal_o              instruction not ALU-class or malformed
module ex_issue (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        in_valid_i,
  output logic        in_ready_o,
  input  logic [31:0] in_instr_i,
  input  logic [31:0] in_pc_i,
  input  logic [31:0] in_rs1_val_i,
  input  logic [31:0] in_rs2_val_i,
  input  logic        fwd_exm_valid_i,
  input  logic [4:0]  fwd_exm_rd_i,
  input  logic [31:0] fwd_exm_data_i,
  input  logic        fwd_wb_valid_i,
  input  logic [4:0]  fwd_wb_rd_i,
  input  logic [31:0] fwd_wb_data_i,
  input  logic        flush_i,
  output logic        out_valid_o,
  input  logic        out_ready_i,
  output logic [31:0] out_arg_a_o,
  output logic [31:0] out_arg_b_o,
  output logic [3:0]  out_alu_sel_o,
  output logic [4:0]  out_rd_o,
  output logic        out_rd_we_o,
  output logic        out_illegal_o
);

  typedef enum logic [3:0] {
    ALU_NONE = 4'h0,
    ALU_ADD  = 4'h1,
    ALU_SUB  = 4'h2,
    ALU_XOR  = 4'h3,
    ALU_OR   = 4'h4,
    ALU_AND  = 4'h5,
    ALU_SLL  = 4'h6,
    ALU_SRL  = 4'h7,
    ALU_SRA  = 4'h8,
    ALU_SLT  = 4'h9,
    ALU_SLTU = 4'hA
  } alu_sel_e;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

  // Instruction fields
  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [6:0] funct7;
  logic [4:0] rd_idx;

  assign opcode = in_instr_i[6:0];
  assign funct3 = in_instr_i[14:12];
  assign funct7 = in_instr_i[31:25];
  assign rd_idx = in_instr_i[11:7];

  // Operand forwarding: index 0 -> rs1, index 1 -> rs2.
  logic [4:0]  src_idx [2];
  logic [31:0] src_rf  [2];
  logic [31:0] src_val [2];

  assign src_idx[0] = in_instr_i[19:15];
  assign src_idx[1] = in_instr_i[24:20];
  assign src_rf[0]  = in_rs1_val_i;
  assign src_rf[1]  = in_rs2_val_i;

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_fwd
      // x0 is hard zero even if a bypass claims rd==0; EX/MEM is younger than
      // MEM/WB so it wins when both match.
      assign src_val[gi] =
          (src_idx[gi] == 5'd0)                              ? 32'd0          :
          (fwd_exm_valid_i && (fwd_exm_rd_i == src_idx[gi])) ? fwd_exm_data_i :
          (fwd_wb_valid_i  && (fwd_wb_rd_i  == src_idx[gi])) ? fwd_wb_data_i  :
                                                               src_rf[gi];
    end
  endgenerate

  // Decode
  alu_sel_e    dec_sel;
  logic [31:0] dec_a;
  logic [31:0] dec_b;
  logic        dec_ill;
  logic        dec_we;
  alu_sel_e    base_sel;

  // funct3 to ALU op shared by OP and OP-IMM; funct7[5] selects SUB/SRA.
  // For OP-IMM funct3 000 is always ADDI, so the SUB variant is masked there.
  always_comb begin
    base_sel = ALU_NONE;
    unique case (funct3)
      3'b000:  base_sel = (funct7[5] && (opcode == OPC_OP)) ? ALU_SUB : ALU_ADD;
      3'b001:  base_sel = ALU_SLL;
      3'b010:  base_sel = ALU_SLT;
      3'b011:  base_sel = ALU_SLTU;
      3'b100:  base_sel = ALU_XOR;
      3'b101:  base_sel = funct7[5] ? ALU_SRA : ALU_SRL;
      3'b110:  base_sel = ALU_OR;
      default: base_sel = ALU_AND;
    endcase
  end

  always_comb begin
    dec_sel = ALU_NONE;
    dec_a   = 32'd0;
    dec_b   = 32'd0;
    dec_ill = 1'b1;
    unique case (opcode)
      OPC_OP: begin
        dec_a   = src_val[0];
        dec_b   = src_val[1];
        dec_sel = base_sel;
        dec_ill = !((funct7 == 7'h00) ||
                    ((funct7 == 7'h20) && ((funct3 == 3'b000) || (funct3 == 3'b101))));
      end
      OPC_OP_IMM: begin
        dec_a   = src_val[0];
        dec_sel = base_sel;
        if ((funct3 == 3'b001) || (funct3 == 3'b101)) begin
          // Shifts use the 5-bit shamt only; the upper bits are funct7.
          dec_b   = {27'd0, in_instr_i[24:20]};
          dec_ill = (funct3 == 3'b001) ? (funct7 != 7'h00)
                                       : !((funct7 == 7'h00) || (funct7 == 7'h20));
        end else begin
          dec_b   = {{20{in_instr_i[31]}}, in_instr_i[31:20]};
          dec_ill = 1'b0;
        end
      end
      OPC_LUI: begin
        dec_a   = 32'd0;
        dec_b   = {in_instr_i[31:12], 12'd0};
        dec_sel = ALU_ADD;
        dec_ill = 1'b0;
      end
      OPC_AUIPC: begin
        dec_a   = in_pc_i;
        dec_b   = {in_instr_i[31:12], 12'd0};
        dec_sel = ALU_ADD;
        dec_ill = 1'b0;
      end
      default: begin
        dec_ill = 1'b1;
      end
    endcase
    // Illegal entries still flow downstream but carry no operation.
    if (dec_ill) begin
      dec_sel = ALU_NONE;
      dec_a   = 32'd0;
      dec_b   = 32'd0;
    end
  end

  assign dec_we = !dec_ill && (rd_idx != 5'd0);

  // Pipeline register
  logic        valid_q,   valid_d;
  logic [31:0] arg_a_q,   arg_a_d;
  logic [31:0] arg_b_q,   arg_b_d;
  logic [3:0]  alu_sel_q, alu_sel_d;
  logic [4:0]  rd_q,      rd_d;
  logic        rd_we_q,   rd_we_d;
  logic        illegal_q, illegal_d;
  logic        accept;

  assign in_ready_o = rst_ni && !flush_i && (!valid_q || out_ready_i);
  assign accept     = in_valid_i && in_ready_o;

  always_comb begin
    valid_d   = valid_q;
    arg_a_d   = arg_a_q;
    arg_b_d   = arg_b_q;
    alu_sel_d = alu_sel_q;
    rd_d      = rd_q;
    rd_we_d   = rd_we_q;
    illegal_d = illegal_q;
    if (flush_i) begin
      valid_d = 1'b0;
    end else if (accept) begin
      valid_d   = 1'b1;
      arg_a_d   = dec_a;
      arg_b_d   = dec_b;
      alu_sel_d = dec_sel;
      rd_d      = rd_idx;
      rd_we_d   = dec_we;
      illegal_d = dec_ill;
    end else if (out_ready_i) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      valid_q   <= 1'b0;
      arg_a_q   <= 32'd0;
      arg_b_q   <= 32'd0;
      alu_sel_q <= 4'd0;
      rd_q      <= 5'd0;
      rd_we_q   <= 1'b0;
      illegal_q <= 1'b0;
    end else begin
      valid_q   <= valid_d;
      arg_a_q   <= arg_a_d;
      arg_b_q   <= arg_b_d;
      alu_sel_q <= alu_sel_d;
      rd_q      <= rd_d;
      rd_we_q   <= rd_we_d;
      illegal_q <= illegal_d;
    end
  end

  assign out_valid_o   = valid_q;
  assign out_arg_a_o   = arg_a_q;
  assign out_arg_b_o   = arg_b_q;
  assign out_alu_sel_o = alu_sel_q;
  assign out_rd_o      = rd_q;
  assign out_rd_we_o   = rd_we_q;
  assign out_illegal_o = illegal_q;

endmodule

// File: tb/tb_ex_issue.sv
// Testbench for ex_issue: directed cases followed by randomized traffic.
// Accepted instructions are decoded by a reference model into a scoreboard
// queue; a monitor process compares every presented entry against it.
module tb_ex_issue;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_instr, in_pc, in_rs1_val, in_rs2_val;
  logic        fwd_exm_valid, fwd_wb_valid;
  logic [4:0]  fwd_exm_rd, fwd_wb_rd;
  logic [31:0] fwd_exm_data, fwd_wb_data;
  logic        flush;
  logic        out_valid, out_ready;
  logic [31:0] out_arg_a, out_arg_b;
  logic [3:0]  out_alu_sel;
  logic [4:0]  out_rd;
  logic        out_rd_we, out_illegal;

  always #5 clk = ~clk;

  ex_issue dut (
    .clk_i          (clk),
    .rst_ni         (rst_n),
    .in_valid_i     (in_valid),
    .in_ready_o     (in_ready),
    .in_instr_i     (in_instr),
    .in_pc_i        (in_pc),
    .in_rs1_val_i   (in_rs1_val),
    .in_rs2_val_i   (in_rs2_val),
    .fwd_exm_valid_i(fwd_exm_valid),
    .fwd_exm_rd_i   (fwd_exm_rd),
    .fwd_exm_data_i (fwd_exm_data),
    .fwd_wb_valid_i (fwd_wb_valid),
    .fwd_wb_rd_i    (fwd_wb_rd),
    .fwd_wb_data_i  (fwd_wb_data),
    .flush_i        (flush),
    .out_valid_o    (out_valid),
    .out_ready_i    (out_ready),
    .out_arg_a_o    (out_arg_a),
    .out_arg_b_o    (out_arg_b),
    .out_alu_sel_o  (out_alu_sel),
    .out_rd_o       (out_rd),
    .out_rd_we_o    (out_rd_we),
    .out_illegal_o  (out_illegal)
  );

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] b;
    logic [3:0]  sel;
    logic [4:0]  rd;
    logic        we;
    logic        ill;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   txn    = 0;
  bit   mon_en = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", nm, act, req);
    end
  endtask

  // Source operand value as seen by an instruction, from the bypass rules.
  function automatic logic [31:0] opnd(input logic [4:0] idx, input logic [31:0] rf);
    if (idx == 0) return 32'd0;
    if (fwd_exm_valid && fwd_exm_rd == idx) return fwd_exm_data;
    if (fwd_wb_valid && fwd_wb_rd == idx) return fwd_wb_data;
    return rf;
  endfunction

  // Reference decode of the current inputs.
  function automatic exp_t model();
    exp_t e;
    logic [6:0] op  = in_instr[6:0];
    logic [2:0] f3  = in_instr[14:12];
    logic [6:0] f7  = in_instr[31:25];
    logic [31:0] a  = opnd(in_instr[19:15], in_rs1_val);
    logic [31:0] b  = opnd(in_instr[24:20], in_rs2_val);
    logic [3:0] tbl [8] = '{4'h1, 4'h6, 4'h9, 4'hA, 4'h3, 4'h7, 4'h4, 4'h5};
    e = '0;
    e.rd  = in_instr[11:7];
    e.ill = 1'b1;
    if (op == 7'h33) begin
      if (f7 == 7'h00 || (f7 == 7'h20 && (f3 == 3'd0 || f3 == 3'd5))) begin
        e.ill = 1'b0;
        e.a   = a;
        e.b   = b;
        e.sel = tbl[f3];
        if (f7 == 7'h20) e.sel = (f3 == 3'd0) ? 4'h2 : 4'h8;
      end
    end else if (op == 7'h13) begin
      if (!((f3 == 3'd1 && f7 != 7'h00) ||
            (f3 == 3'd5 && f7 != 7'h00 && f7 != 7'h20))) begin
        e.ill = 1'b0;
        e.a   = a;
        e.sel = tbl[f3];
        if (f3 == 3'd5 && f7 == 7'h20) e.sel = 4'h8;
        if (f3 == 3'd1 || f3 == 3'd5) e.b = {27'd0, in_instr[24:20]};
        else e.b = {{20{in_instr[31]}}, in_instr[31:20]};
      end
    end else if (op == 7'h37 || op == 7'h17) begin
      e.ill = 1'b0;
      e.a   = (op == 7'h17) ? in_pc : 32'd0;
      e.b   = {in_instr[31:12], 12'd0};
      e.sel = 4'h1;
    end
    e.we = !e.ill && (e.rd != 0);
    return e;
  endfunction

  // Monitor: at each falling edge compares handshake state and the presented
  // entry against the scoreboard; retires the entry if it leaves this edge.
  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (mon_en && rst_n) begin
        chk("out_valid", {31'd0, out_valid}, {31'd0, sb.size() != 0});
        chk("in_ready", {31'd0, in_ready},
            {31'd0, !flush && (sb.size() == 0 || out_ready)});
        if (out_valid && sb.size() != 0) begin
          e = sb[0];
          chk("arg_a", out_arg_a, e.a);
          chk("arg_b", out_arg_b, e.b);
          chk("alu_sel", {28'd0, out_alu_sel}, {28'd0, e.sel});
          chk("rd", {27'd0, out_rd}, {27'd0, e.rd});
          chk("rd_we", {31'd0, out_rd_we}, {31'd0, e.we});
          chk("illegal", {31'd0, out_illegal}, {31'd0, e.ill});
          if (flush || out_ready) begin
            txn++;
            $display("txn %0d %s sel=%h a=%h b=%h rd=%0d we=%0d ill=%0d",
                     txn, flush ? "flushed" : "consumed", e.sel, e.a, e.b, e.rd, e.we, e.ill);
            void'(sb.pop_front());
          end
        end
      end
    end
  end

  // Called at posedge+1: drive one cycle, record acceptance, return at the
  // next posedge+1 so registered outputs can be inspected.
  task automatic step(input logic v, input logic [31:0] instr, input logic [31:0] pc,
                      input logic [31:0] r1, input logic [31:0] r2,
                      input logic fl, input logic ordy);
    in_valid   = v;
    in_instr   = instr;
    in_pc      = pc;
    in_rs1_val = r1;
    in_rs2_val = r2;
    flush      = fl;
    out_ready  = ordy;
    @(negedge clk);
    #1;
    if (in_valid && in_ready) sb.push_back(model());
    @(posedge clk);
    #1;
  endtask

  task automatic fwd_set(input logic ev, input logic [4:0] erd, input logic [31:0] ed,
                         input logic wv, input logic [4:0] wrd, input logic [31:0] wd);
    fwd_exm_valid = ev;
    fwd_exm_rd    = erd;
    fwd_exm_data  = ed;
    fwd_wb_valid  = wv;
    fwd_wb_rd     = wrd;
    fwd_wb_data   = wd;
  endtask

  function automatic logic [31:0] rand_instr();
    logic [31:0] r = $urandom;
    int kind = $urandom_range(0, 9);
    int f7k  = $urandom_range(0, 3);
    if (kind <= 3) r[6:0] = 7'h33;
    else if (kind <= 6) r[6:0] = 7'h13;
    else if (kind == 7) r[6:0] = 7'h37;
    else if (kind == 8) r[6:0] = 7'h17;
    if (kind <= 6) begin
      if (f7k <= 1) r[31:25] = 7'h00;
      else if (f7k == 2) r[31:25] = 7'h20;
      r[19:15] = 5'($urandom_range(0, 3));
      r[24:20] = 5'($urandom_range(0, 3));
    end
    return r;
  endfunction

  initial begin : stim
    logic [31:0] held_a;
    rst_n = 1'b0;
    fwd_set(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    in_valid = 1'b1; in_instr = 32'h002081B3; in_pc = 32'h40;
    in_rs1_val = 32'h5; in_rs2_val = 32'h7; flush = 1'b0; out_ready = 1'b1;

    // Reset with a valid input pending
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_arg_a", out_arg_a, 32'd0);
    chk("rst_arg_b", out_arg_b, 32'd0);
    chk("rst_alu_sel", {28'd0, out_alu_sel}, 32'd0);
    chk("rst_rd", {27'd0, out_rd}, 32'd0);
    chk("rst_rd_we", {31'd0, out_rd_we}, 32'd0);
    chk("rst_illegal", {31'd0, out_illegal}, 32'd0);
    chk("rst_in_ready", {31'd0, in_ready}, 32'd0);
    rst_n  = 1'b1;
    mon_en = 1'b1;

    // ADD x3,x1,x2
    step(1'b1, 32'h002081B3, 32'h0, 32'd5, 32'd7, 1'b0, 1'b1);
    chk("add_valid", {31'd0, out_valid}, 32'd1);
    chk("add_a", out_arg_a, 32'd5);
    chk("add_b", out_arg_b, 32'd7);
    chk("add_sel", {28'd0, out_alu_sel}, 32'd1);
    chk("add_rd", {27'd0, out_rd}, 32'd3);
    chk("add_we", {31'd0, out_rd_we}, 32'd1);
    // SRAI x4,x4,3
    step(1'b1, 32'h40325213, 32'h0, 32'd9, 32'd0, 1'b0, 1'b1);
    chk("srai_sel", {28'd0, out_alu_sel}, 32'd8);
    chk("srai_b", out_arg_b, 32'd3);
    chk("srai_a", out_arg_a, 32'd9);
    // AUIPC x1,0x12345 at pc 0x100
    step(1'b1, 32'h12345097, 32'h100, 32'd0, 32'd0, 1'b0, 1'b1);
    chk("auipc_a", out_arg_a, 32'h100);
    chk("auipc_b", out_arg_b, 32'h12345000);
    chk("auipc_sel", {28'd0, out_alu_sel}, 32'd1);
    // OP with funct7 0x20 and funct3 001
    step(1'b1, 32'h40209133, 32'h0, 32'd1, 32'd2, 1'b0, 1'b1);
    chk("bad_f7_ill", {31'd0, out_illegal}, 32'd1);
    chk("bad_f7_sel", {28'd0, out_alu_sel}, 32'd0);
    chk("bad_f7_we", {31'd0, out_rd_we}, 32'd0);
    // LW
    step(1'b1, 32'h00012083, 32'h0, 32'd1, 32'd2, 1'b0, 1'b1);
    chk("lw_ill", {31'd0, out_illegal}, 32'd1);

    // Forwarding priority
    fwd_set(1'b1, 5'd5, 32'hAA, 1'b1, 5'd5, 32'hBB);
    step(1'b1, 32'h000281B3, 32'h0, 32'h11, 32'h0, 1'b0, 1'b1);
    chk("fwd_exm", out_arg_a, 32'hAA);
    fwd_set(1'b0, 5'd5, 32'hAA, 1'b1, 5'd5, 32'hBB);
    step(1'b1, 32'h000281B3, 32'h0, 32'h11, 32'h0, 1'b0, 1'b1);
    chk("fwd_wb", out_arg_a, 32'hBB);
    fwd_set(1'b1, 5'd0, 32'hAA, 1'b1, 5'd0, 32'hBB);
    step(1'b1, 32'h000001B3, 32'h0, 32'h11, 32'h0, 1'b0, 1'b1);
    chk("fwd_x0", out_arg_a, 32'h0);
    fwd_set(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);

    // Backpressure: ADDI x1,x1,0x55 then stall four cycles
    step(1'b1, 32'h05508093, 32'h0, 32'h1000, 32'h0, 1'b0, 1'b1);
    held_a = 32'h1000;
    for (int i = 0; i < 4; i++) begin
      step(1'b1, 32'h002081B3, 32'h0, 32'h77, 32'h1, 1'b0, 1'b0);
      chk("bp_in_ready", {31'd0, in_ready}, 32'd0);
      chk("bp_valid", {31'd0, out_valid}, 32'd1);
      chk("bp_hold_a", out_arg_a, held_a);
      chk("bp_hold_b", out_arg_b, 32'h55);
    end
    step(1'b1, 32'h002081B3, 32'h0, 32'h77, 32'h1, 1'b0, 1'b1);
    chk("bp_release_valid", {31'd0, out_valid}, 32'd1);
    chk("bp_release_a", out_arg_a, 32'h77);
    chk("bp_release_sel", {28'd0, out_alu_sel}, 32'd1);

    // Flush while holding an entry with a same-cycle input
    step(1'b1, 32'h40208133, 32'h0, 32'h30, 32'h10, 1'b1, 1'b0);
    chk("flush_in_ready", {31'd0, in_ready}, 32'd0);
    chk("flush_valid", {31'd0, out_valid}, 32'd0);
    step(1'b1, 32'h40208133, 32'h0, 32'h30, 32'h10, 1'b0, 1'b1);
    chk("post_flush_valid", {31'd0, out_valid}, 32'd1);
    chk("post_flush_sel", {28'd0, out_alu_sel}, 32'd2);
    chk("post_flush_a", out_arg_a, 32'h30);

    // Randomized traffic
    for (int n = 0; n < 1500; n++) begin
      fwd_set(1'($urandom_range(0, 1)), 5'($urandom_range(0, 3)), $urandom,
              1'($urandom_range(0, 1)), 5'($urandom_range(0, 3)), $urandom);
      step(1'($urandom_range(0, 3) != 0), rand_instr(), $urandom, $urandom, $urandom,
           1'($urandom_range(0, 19) == 0), 1'($urandom_range(0, 9) < 7));
    end

    // Drain
    repeat (3) step(1'b0, 32'h0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b1);
    chk("drained", {31'd0, out_valid}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
